// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  lfsr_pkg
//  Shared definitions for the 4-bit Fibonacci LFSR generator and its checker:
//  checker state encoding, default LFSR geometry and the generator seed.
//  Revision: 1.0
// ============================================================================
package lfsr_pkg;

  // Checker synchronisation state
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Default LFSR geometry: x^4 + x^3 + 1, feedback out3 ^ out2
  localparam int LFSR_WIDTH = 4;
  localparam int LFSR_TAP_A = 3;
  localparam int LFSR_TAP_B = 2;

  // Generator reset seed, {out3, out2, out1, out0}
  localparam logic [3:0] GEN_SEED = 4'b1010;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  sat_counter
//  Up counter that sticks at all-ones. A clear wins over a same-cycle
//  increment.
//  Revision: 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count up on inc until all-ones; clr or rst return to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
//  prbs4_checker
//  Self-synchronising checker for the x^4+x^3+1 PRBS stream. Fills its shift
//  register from the line, verifies a run of correct predictions, then
//  flywheels on its own predictions while counting line mismatches.
//  Revision: 1.0
// ============================================================================
module prbs4_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH         = LFSR_WIDTH,
  parameter int TAP_A         = LFSR_TAP_A,
  parameter int TAP_B         = LFSR_TAP_B,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             lock_lost
);

  localparam int                FILL_W      = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_ONE    = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(WIDTH);
  localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_THRESH - 1);
  localparam logic [7:0]        UNLOCK_LAST = 8'(UNLOCK_THRESH - 1);

  state_t            state;
  logic [WIDTH-1:0]  sr;          // sr[0] is the newest bit
  logic [FILL_W-1:0] fill_cnt;
  logic [7:0]        match_cnt;
  logic [7:0]        miss_cnt;

  logic pred;
  logic sr_zero;
  logic mismatch;
  logic count_err;

  assign pred      = sr[TAP_A] ^ sr[TAP_B];
  assign sr_zero   = (sr == '0);
  assign mismatch  = din ^ pred;
  // Only line errors seen while flywheeling are counted
  assign count_err = din_valid && (state == LOCKED) && mismatch;

  // Synchronisation FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            sr <= {sr[WIDTH-2:0], din};
            if (fill_cnt == FILL_LAST) begin
              fill_cnt  <= FILL_FULL;
              match_cnt <= '0;
              state     <= VERIFY;
            end else begin
              fill_cnt <= fill_cnt + FILL_ONE;
            end
          end
          VERIFY: begin
            sr <= {sr[WIDTH-2:0], din};
            // The all-zero lockup pattern predicts itself and never qualifies
            if (!mismatch && !sr_zero) begin
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
              match_cnt <= match_cnt + 8'd1;
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on our own prediction so one line error counts once
            sr <= {sr[WIDTH-2:0], pred};
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (miss_cnt == UNLOCK_LAST) begin
                state     <= HUNT;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                fill_cnt  <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
      // Clearing beats a same-cycle lock-loss set
      if (clear_cnt) begin
        lock_lost <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_err),
    .clr   (clear_cnt),
    .count (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// ============================================================================
//  tb_prbs4_checker
//  Drives two checkers (full-width and narrow error counter) from a PRBS
//  generator with injected errors and compares every cycle to a reference.
//  Revision: 1.0
// ============================================================================
module tb_prbs4_checker;
  import lfsr_pkg::*;

  localparam int     CNT_W   = 16;
  localparam int     CNT_W_S = 4;
  localparam int     LOCK_T  = 8;
  localparam int     UNLOCK_T = 3;
  localparam longint MAX_L   = (longint'(1) << CNT_W) - 1;
  localparam longint MAX_S   = (longint'(1) << CNT_W_S) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clear_cnt = 1'b0;

  logic               locked, err_pulse, lock_lost;
  logic [CNT_W-1:0]   err_count;
  logic               locked_s, err_pulse_s, lock_lost_s;
  logic [CNT_W_S-1:0] err_count_s;

  always #5 clk = ~clk;

  prbs4_checker #(
    .WIDTH(4), .TAP_A(3), .TAP_B(2),
    .LOCK_THRESH(LOCK_T), .UNLOCK_THRESH(UNLOCK_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .lock_lost(lock_lost)
  );

  prbs4_checker #(
    .WIDTH(4), .TAP_A(3), .TAP_B(2),
    .LOCK_THRESH(LOCK_T), .UNLOCK_THRESH(UNLOCK_T), .CNT_W(CNT_W_S)
  ) dut_s (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .clear_cnt(clear_cnt), .locked(locked_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .lock_lost(lock_lost_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = filling, 1 = verifying, 2 = locked
  int     m_mode, m_fill, m_run, m_miss;
  bit     m_hist[$];          // last four bits, oldest first
  bit     e_locked, e_pulse, e_lost;
  longint e_cnt, e_cnt_s;
  bit     model_on = 1'b0;

  task automatic model_step(input bit r, input bit v, input bit d, input bit c);
    bit p, z;
    if (r) begin
      m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0;
      m_hist = '{0, 0, 0, 0};
      e_locked = 0; e_pulse = 0; e_lost = 0; e_cnt = 0; e_cnt_s = 0;
      model_on = 1'b1;
      return;
    end
    e_pulse = 0;
    if (v) begin
      // Next bit of x^4+x^3+1 is b[n-4] ^ b[n-3]
      p = m_hist[0] ^ m_hist[1];
      z = (m_hist[0] == 0) && (m_hist[1] == 0) && (m_hist[2] == 0) && (m_hist[3] == 0);
      if (m_mode == 0) begin
        m_hist.push_back(d);
        m_fill++;
        if (m_fill == 4) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        m_hist.push_back(d);
        if (d == p && !z) begin
          m_run++;
          if (m_run == LOCK_T) begin m_mode = 2; e_locked = 1; m_miss = 0; end
        end else begin
          m_run = 0;
        end
      end else begin
        m_hist.push_back(p);
        if (d != p) begin
          e_pulse = 1;
          if (e_cnt < MAX_L) e_cnt++;
          if (e_cnt_s < MAX_S) e_cnt_s++;
          m_miss++;
          if (m_miss == UNLOCK_T) begin
            m_mode = 0; m_fill = 0; m_miss = 0; e_locked = 0; e_lost = 1;
          end
        end else begin
          m_miss = 0;
        end
      end
      void'(m_hist.pop_front());
    end
    if (c) begin e_cnt = 0; e_cnt_s = 0; e_lost = 0; end
  endtask

  // Compare both checkers to the model shortly after every active edge
  always @(posedge clk) begin
    #2;
    if (model_on) begin
      chk("locked",      locked,      e_locked);
      chk("err_pulse",   err_pulse,   e_pulse);
      chk("err_count",   err_count,   e_cnt);
      chk("lock_lost",   lock_lost,   e_lost);
      chk("locked_s",    locked_s,    e_locked);
      chk("err_pulse_s", err_pulse_s, e_pulse);
      chk("err_count_s", err_count_s, e_cnt_s);
      chk("lock_lost_s", lock_lost_s, e_lost);
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] g = GEN_SEED;   // generator state, out0 = g[0]

  // Called at a negedge; returns at the next negedge
  task automatic tick_raw(input bit r, input bit v, input bit d, input bit c);
    rst = r; din_valid = v; din = d; clear_cnt = c;
    model_step(r, v, d, c);
    @(negedge clk);
  endtask

  task automatic tick(input bit r, input bit v, input bit e, input bit c);
    bit d;
    if (v) begin
      d = g[0] ^ e;
      g = {g[2:0], g[3] ^ g[2]};
    end else begin
      d = 1'($urandom);
    end
    tick_raw(r, v, d, c);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0);
  endtask

  initial begin
    int burst;
    bit r, v, e, c;

    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("reset_locked", locked, 0);
    chk("reset_count",  err_count, 0);

    // Lock after 4 fill + 8 matches
    clean(11);
    chk("no_lock_at_11", locked, 0);
    clean(1);
    chk("lock_at_12", locked, 1);
    clean(1000);
    chk("clean_1000_count", err_count, 0);
    chk("clean_1000_locked", locked, 1);

    // Single line error
    tick(0, 1, 1, 0);
    chk("single_pulse", err_pulse, 1);
    chk("single_count", err_count, 1);
    chk("single_locked", locked, 1);
    clean(1);
    chk("single_pulse_gone", err_pulse, 0);
    clean(20);
    chk("single_no_more", err_count, 1);

    // Three consecutive errors drop lock
    tick(0, 1, 0, 1);
    chk("cleared_count", err_count, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0);
    chk("burst_count", err_count, 3);
    chk("burst_unlock", locked, 0);
    chk("burst_lost", lock_lost, 1);
    clean(11);
    chk("relock_not_yet", locked, 0);
    clean(1);
    chk("relock_12", locked, 1);
    chk("relock_count", err_count, 3);

    // All-zero input never locks
    tick(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) tick_raw(0, 1, 0, 0);
    chk("zero_no_lock", locked, 0);
    chk("zero_count", err_count, 0);

    // Valid on every other cycle
    tick(1, 0, 0, 0);
    for (int i = 0; i < 22; i++) tick(0, (i % 2) == 0, 0, 0);
    chk("half_rate_not_yet", locked, 0);
    tick(0, 1, 0, 0);
    chk("half_rate_lock", locked, 1);
    tick(0, 0, 0, 0);
    chk("idle_keeps_lock", locked, 1);

    // Error together with clear
    tick(0, 1, 1, 1);
    chk("clr_err_count", err_count, 0);
    chk("clr_err_pulse", err_pulse, 1);

    // Lose lock, relock, then reset while locked
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0);
    clean(12);
    chk("pre_rst_lost", lock_lost, 1);
    chk("pre_rst_locked", locked, 1);
    tick(1, 1, 1, 1);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_count", err_count, 0);
    chk("rst_lost", lock_lost, 0);

    // Saturation of the narrow counter
    clean(12);
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1, 0);
      tick(0, 1, 0, 0);
    end
    chk("sat_wide", err_count, 20);
    chk("sat_narrow", err_count_s, 15);
    chk("sat_locked", locked, 1);

    // Randomised traffic
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 999) < 3);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) < 2);
      if (burst > 0) begin
        e = 1; burst--;
      end else begin
        e = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 299) == 0) burst = 3;
      end
      tick(r, v, e, c);
    end

    tick(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
